// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bcd_pkg;
    localparam int BIN_W  = 14;
    localparam int NDIG   = 4;
    localparam int BCD_W  = 4 * NDIG;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int ITER   = 14;
    localparam int CNT_W  = 4;

    localparam logic [BIN_W-1:0] BIN_MAX   = 14'd9999;
    localparam logic [BCD_W-1:0] BCD_SAT   = 16'h9999;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble step per clock.
module bin2bcd_seq
    import bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd,
    output logic              ovf
);
    state_t              state;
    logic [WORK_W-1:0]   work;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_flag;
    logic [BCD_W-1:0]    corr;
    logic [WORK_W-1:0]   shifted;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (work[BIN_W + 4*i +: 4]),
            .dout (corr[4*i +: 4])
        );
    end

    // Corrected BCD nibbles and the remaining binary bits shift left as one word.
    assign shifted = {corr[BCD_W-2:0], work[BIN_W-1:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // busy stays high through the cycle after commit, so it drops one edge after DONE.
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        work     <= {{BCD_W{1'b0}}, bin};
                        cnt      <= '0;
                        ovf_flag <= (bin > BIN_MAX);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt + 1'b1;
                    if (cnt == ITER_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= ovf_flag ? BCD_SAT : work[WORK_W-1:BIN_W];
                    ovf   <= ovf_flag;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: timing/value model plus directed and random stimulus.
module tb_bin2bcd_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age counts edges since the accepting edge; commit lands 15 edges later.
    int          age;
    int          pbin;
    logic [15:0] ebcd;
    logic        eovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age  <= 0;
            pbin <= 0;
            ebcd <= 16'h0000;
            eovf <= 1'b0;
        end else begin
            if ((age == 0 || age == 16) && start) begin
                age  <= 1;
                pbin <= int'(bin);
            end else if (age == 16) begin
                age <= 0;
            end else if (age != 0) begin
                age <= age + 1;
            end
            if (age == 15) begin
                ebcd <= to_bcd(pbin);
                eovf <= (pbin > 9999);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {31'd0, busy}, {31'd0, (age != 0)});
            chk("done", {31'd0, done}, {31'd0, (age == 16)});
            chk("bcd",  {16'd0, bcd},  {16'd0, ebcd});
            chk("ovf",  {31'd0, ovf},  {31'd0, eovf});
        end
    end

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
        wait_done(lat);
        chk("latency", lat, 16);
        chk("conv_bcd", {16'd0, bcd}, {16'd0, exp_bcd});
        chk("conv_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        int lat;
        int bcnt;
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_bcd",  {16'd0, bcd},  0);
        chk("rst_ovf",  {31'd0, ovf},  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        // 1234 with busy-width measurement
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        bcnt  = 0;
        lat   = 1;
        while (busy && lat < 40) begin
            bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("busy_width", bcnt, 16);
        chk("bcd_1234", {16'd0, bcd}, 32'h1234);
        chk("ovf_1234", {31'd0, ovf}, 0);

        run_conv(14'd0,     16'h0000, 1'b0);
        run_conv(14'd9,     16'h0009, 1'b0);
        run_conv(14'd10,    16'h0010, 1'b0);
        run_conv(14'd9999,  16'h9999, 1'b0);
        run_conv(14'd10000, 16'h9999, 1'b1);
        run_conv(14'd42,    16'h0042, 1'b0);
        run_conv(14'd16383, 16'h9999, 1'b1);

        // start at E3 with a different operand is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd1234;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("e3_done_seen", {31'd0, done}, 1);
        chk("e3_bcd", {16'd0, bcd}, 32'h1234);
        @(negedge clk);

        // start held: back-to-back conversions of 0..20
        start = 1'b1;
        bin   = 14'd0;
        for (int v = 1; v <= 21; v++) begin
            @(negedge clk);
            wait_done(lat);
            chk("b2b_done", {31'd0, done}, 1);
            chk("b2b_bcd", {16'd0, bcd}, {16'd0, to_bcd(v - 1)});
            bin = 14'(v);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        // reset at E7 of a 5678 conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_bcd",  {16'd0, bcd},  0);
        chk("mid_rst_done", {31'd0, done}, 0);
        #1 rst = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) bcnt++;
        end
        chk("no_done_after_abort", bcnt, 0);
        run_conv(14'd5678, 16'h5678, 1'b0);

        // random stimulus with random start and operand churn
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                bin = 14'($urandom_range(9990, 10010));
            else
                bin = 14'($urandom_range(0, 16383));
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
